// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, cache_controller and the SRAM controller.
// slave: the cache's view of the bus; master: the pipeline/SRAM-controller side.
interface cache_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
    );

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_read_en, sram_write_en
    );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative write-through read cache (64 sets, 64-bit lines) in front of the SRAM controller.
// Define CACHE_WRITE_UPDATE_EN to update a hitting line on stores instead of invalidating it.
module cache_controller (
    input  logic              clk,
    input  logic              rst,
    cache_controller_if.slave bus
);
    // state        | meaning
    // ST_IDLE      | serving hits, accepting new requests
    // ST_READ_MISS | line fill in progress on the SRAM controller
    // ST_WRITE     | store being forwarded to SRAM
    typedef enum logic [1:0] {ST_IDLE, ST_READ_MISS, ST_WRITE} state_t;

    state_t      state_q, state_d;
    logic        seen_low_q, seen_low_d;
    logic        sram_read_en_q, sram_read_en_d;
    logic        sram_write_en_q, sram_write_en_d;
    logic [31:0] sram_address_q, sram_address_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic [63:0] valid0_q, valid0_d;
    logic [63:0] valid1_q, valid1_d;
    logic [63:0] lru_q, lru_d;

    logic [9:0]  tag0_q  [0:63];
    logic [9:0]  tag1_q  [0:63];
    logic [63:0] data0_q [0:63];
    logic [63:0] data1_q [0:63];

    // Data space starts at byte 1024; subtracting at word granularity keeps only the bits we decode.
    logic [16:0] a_word;
    logic        word_sel;
    logic [5:0]  set_idx;
    logic [9:0]  tag;
    assign a_word   = bus.address[18:2] - 17'd256;
    assign word_sel = a_word[0];
    assign set_idx  = a_word[6:1];
    assign tag      = a_word[16:7];

    logic        hit0, hit1, hit_any, victim;
    logic [63:0] hit_line;
    logic [31:0] hit_word, fill_word;
    assign hit0      = valid0_q[set_idx] && (tag0_q[set_idx] == tag);
    assign hit1      = valid1_q[set_idx] && (tag1_q[set_idx] == tag);
    assign hit_any   = hit0 || hit1;
    assign hit_line  = hit1 ? data1_q[set_idx] : data0_q[set_idx];
    assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
    assign fill_word = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
    assign victim    = !valid0_q[set_idx] ? 1'b0 :
                       (!valid1_q[set_idx] ? 1'b1 : lru_q[set_idx]);

    logic        fill_we;
    logic        fill_way;
    logic [63:0] fill_data;
    logic        ready;
    logic [31:0] rdata;

    always_comb begin
        state_d         = state_q;
        seen_low_d      = seen_low_q;
        sram_read_en_d  = sram_read_en_q;
        sram_write_en_d = sram_write_en_q;
        sram_address_d  = sram_address_q;
        sram_wdata_d    = sram_wdata_q;
        valid0_d        = valid0_q;
        valid1_d        = valid1_q;
        lru_d           = lru_q;
        fill_we         = 1'b0;
        fill_way        = 1'b0;
        fill_data       = bus.sram_rdata;
        ready           = 1'b1;
        rdata           = 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.MEM_W_EN) begin
                    ready           = 1'b0;
                    state_d         = ST_WRITE;
                    seen_low_d      = 1'b0;
                    sram_write_en_d = 1'b1;
                    sram_address_d  = bus.address;
                    sram_wdata_d    = bus.wdata;
                    if (hit_any) begin
`ifdef CACHE_WRITE_UPDATE_EN
                        fill_we        = 1'b1;
                        fill_way       = hit1;
                        fill_data      = word_sel ? {bus.wdata, hit_line[31:0]}
                                                  : {hit_line[63:32], bus.wdata};
                        lru_d[set_idx] = ~hit1;
`else
                        if (hit1) begin
                            valid1_d[set_idx] = 1'b0;
                        end else begin
                            valid0_d[set_idx] = 1'b0;
                        end
`endif
                    end
                end else if (bus.MEM_R_EN) begin
                    if (hit_any) begin
                        rdata          = hit_word;
                        lru_d[set_idx] = ~hit1;
                    end else begin
                        ready          = 1'b0;
                        state_d        = ST_READ_MISS;
                        seen_low_d     = 1'b0;
                        sram_read_en_d = 1'b1;
                        sram_address_d = bus.address;
                    end
                end
            end
            ST_READ_MISS: begin
                ready = 1'b0;
                // A stale sram_ready from the controller's idle state must not complete the fill.
                if (bus.sram_ready && seen_low_q) begin
                    fill_we        = 1'b1;
                    fill_way       = victim;
                    lru_d[set_idx] = ~victim;
                    if (victim) begin
                        valid1_d[set_idx] = 1'b1;
                    end else begin
                        valid0_d[set_idx] = 1'b1;
                    end
                    rdata          = fill_word;
                    ready          = 1'b1;
                    state_d        = ST_IDLE;
                    sram_read_en_d = 1'b0;
                end else if (!bus.sram_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            ST_WRITE: begin
                ready = 1'b0;
                if (bus.sram_ready && seen_low_q) begin
                    ready           = 1'b1;
                    state_d         = ST_IDLE;
                    sram_write_en_d = 1'b0;
                end else if (!bus.sram_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rst) begin
            ready = 1'b1;
            rdata = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            seen_low_q      <= 1'b0;
            sram_read_en_q  <= 1'b0;
            sram_write_en_q <= 1'b0;
            sram_address_q  <= 32'd0;
            sram_wdata_q    <= 32'd0;
            valid0_q        <= 64'd0;
            valid1_q        <= 64'd0;
            lru_q           <= 64'd0;
        end else begin
            state_q         <= state_d;
            seen_low_q      <= seen_low_d;
            sram_read_en_q  <= sram_read_en_d;
            sram_write_en_q <= sram_write_en_d;
            sram_address_q  <= sram_address_d;
            sram_wdata_q    <= sram_wdata_d;
            valid0_q        <= valid0_d;
            valid1_q        <= valid1_d;
            lru_q           <= lru_d;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            if (fill_way) begin
                tag1_q[set_idx]  <= tag;
                data1_q[set_idx] <= fill_data;
            end else begin
                tag0_q[set_idx]  <= tag;
                data0_q[set_idx] <= fill_data;
            end
        end
    end

    assign bus.ready         = ready;
    assign bus.rdata         = rdata;
    assign bus.sram_read_en  = sram_read_en_q;
    assign bus.sram_write_en = sram_write_en_q;
    assign bus.sram_address  = sram_address_q;
    assign bus.sram_wdata    = sram_wdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, reset-abort sequence, and random traffic
// checked against a memory + per-set recency model; includes a latency-programmable SRAM controller model.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_controller_if bus ();
    cache_controller dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CACHE_WRITE_UPDATE_EN
    localparam bit UPD = 1'b1;
`else
    localparam bit UPD = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int sram_lat = 3;

    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    int t0 [64];
    int t1 [64];

    function automatic logic [31:0] hashw(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, got, want);
        end
    endtask

    // SRAM controller model: idle reports ready=1; a request is busy for sram_lat cycles, then
    // ready=1 until the enable drops.
    assign bus.sram_rdata = {sram_mem[{bus.sram_address[11:3], 1'b1}],
                             sram_mem[{bus.sram_address[11:3], 1'b0}]};

    initial begin : sram_model
        int sst;
        int scnt;
        for (int i = 0; i < 1024; i++) sram_mem[i] = hashw(i);
        sram_mem[256] = 32'hAAAA_AAAA;
        sram_mem[257] = 32'hBBBB_BBBB;
        sst = 0;
        scnt = 0;
        bus.sram_ready = 1'b1;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                sst = 0;
                bus.sram_ready <= 1'b1;
            end else begin
                case (sst)
                    0: if (bus.sram_read_en || bus.sram_write_en) begin
                        sst = 1;
                        scnt = sram_lat - 1;
                        bus.sram_ready <= 1'b0;
                    end
                    1: if (scnt == 0) begin
                        sst = 2;
                        bus.sram_ready <= 1'b1;
                        if (bus.sram_write_en) sram_mem[bus.sram_address[11:2]] = bus.sram_wdata;
                    end else begin
                        scnt = scnt - 1;
                    end
                    default: if (!bus.sram_read_en && !bus.sram_write_en) sst = 0;
                endcase
            end
        end
    end

    // Starts at posedge+1, returns at posedge+1 after the completing edge with requests dropped.
    task automatic access(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd, output bit saw_rd, output bit saw_wr,
                          output bit bus_bad);
        bus.MEM_W_EN = w;
        bus.MEM_R_EN = r;
        bus.address  = addr;
        bus.wdata    = wd;
        cyc = 0; rd = 32'd0; saw_rd = 1'b0; saw_wr = 1'b0; bus_bad = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if ((saw_rd || saw_wr) && !bus.sram_read_en && !bus.sram_write_en && bus.ready !== 1'b1)
                bus_bad = 1'b1;
            if (bus.sram_read_en) saw_rd = 1'b1;
            if (bus.sram_write_en) saw_wr = 1'b1;
            if ((bus.sram_read_en || bus.sram_write_en) && bus.sram_address !== addr) bus_bad = 1'b1;
            if (bus.sram_write_en && bus.sram_wdata !== wd) bus_bad = 1'b1;
            if (bus.ready === 1'b1) break;
        end
        rd = bus.rdata;
        @(posedge clk);
        #1;
        bus.MEM_W_EN = 1'b0;
        bus.MEM_R_EN = 1'b0;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 64; i++) begin
            t0[i] = -1;
            t1[i] = -1;
        end
    endtask

    // Reference: loads return memory contents; each set keeps at most two resident tags, t0 = MRU.
    task automatic mdl_step(input logic w, input logic [31:0] addr, input logic [31:0] wd, input int lat,
                            output int ecyc, output logic [31:0] erd, output bit erden, output bit ewren);
        int a;
        int s;
        int t;
        bit hit;
        a = int'(addr) - 1024;
        s = (a / 8) % 64;
        t = (a / 512) % 1024;
        hit = (t0[s] == t) || (t1[s] == t);
        erd = 32'd0; erden = 1'b0; ewren = 1'b0;
        if (w) begin
            ecyc = lat + 3;
            ewren = 1'b1;
            ref_mem[addr[11:2]] = wd;
            if (hit && UPD) begin
                if (t1[s] == t) begin t1[s] = t0[s]; t0[s] = t; end
            end else if (hit) begin
                if (t0[s] == t) begin t0[s] = t1[s]; t1[s] = -1; end
                else t1[s] = -1;
            end
        end else begin
            erd = ref_mem[addr[11:2]];
            if (hit) begin
                ecyc = 1;
                if (t1[s] == t) begin t1[s] = t0[s]; t0[s] = t; end
            end else begin
                ecyc = lat + 3;
                erden = 1'b1;
                t1[s] = t0[s];
                t0[s] = t;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
        logic [31:0] rd;
        bit          rden;
        bit          wren;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cyc;
        logic [31:0] rd;
        bit srd, swr, bb;
        int ecyc;
        logic [31:0] erd;
        bit erden, ewren;
        int aft;

        aft = UPD ? 1 : 6;
        vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'd0,            6,   32'hAAAA_AAAA, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'd1028, 32'd0,            1,   32'hBBBB_BBBB, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'd1536, 32'd0,            6,   hashw(384),    1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd1024, 32'd0,            1,   32'hAAAA_AAAA, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'd2048, 32'd0,            6,   hashw(512),    1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'd1024, 32'd0,            1,   32'hAAAA_AAAA, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd1536, 32'd0,            6,   hashw(384),    1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd1024, 32'h1234_5678,    6,   32'd0,         1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'd1024, 32'd0,            aft, 32'h1234_5678, !UPD, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'd1600, 32'hCAFE_F00D,    6,   32'd0,         1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'd1600, 32'd0,            6,   32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'd1024, 32'h0BAD_BEEF,    6,   32'd0,         1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'd1024, 32'd0,            aft, 32'h0BAD_BEEF, !UPD, 1'b0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = hashw(i);
        ref_mem[256] = 32'hAAAA_AAAA;
        ref_mem[257] = 32'hBBBB_BBBB;
        mdl_clear();
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.address  = 32'd1024;
        bus.wdata    = 32'd0;

        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 0, bus.ready, 1'b1);
        chk("rst_rdata", 0, bus.rdata, 32'd0);
        chk("rst_rden", 0, bus.sram_read_en, 1'b0);
        chk("rst_wren", 0, bus.sram_write_en, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        sram_lat = 3;
        for (int i = 0; i < 13; i++) begin
            access(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wd, cyc, rd, srd, swr, bb);
            if (vecs[i].w) ref_mem[vecs[i].addr[11:2]] = vecs[i].wd;
            chk("vec_cycles", i, cyc, vecs[i].cyc);
            if (!vecs[i].w) chk("vec_rdata", i, rd, vecs[i].rd);
            chk("vec_rden", i, srd, vecs[i].rden);
            chk("vec_wren", i, swr, vecs[i].wren);
            chk("vec_bus", i, bb, 1'b0);
            chk("vec_en_drop", i, {bus.sram_read_en, bus.sram_write_en}, 2'b00);
        end

        // Reset two cycles into a read miss abandons the fill.
        bus.address  = 32'd1088;
        bus.MEM_R_EN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pending_ready", 0, bus.ready, 1'b0);
        chk("abort_pending_rden", 0, bus.sram_read_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_rden", 0, bus.sram_read_en, 1'b0);
        chk("abort_ready", 0, bus.ready, 1'b1);
        chk("abort_rdata", 0, bus.rdata, 32'd0);
        bus.MEM_R_EN = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        mdl_clear();
        access(1'b0, 1'b1, 32'd1088, 32'd0, cyc, rd, srd, swr, bb);
        chk("abort_remiss_cycles", 0, cyc, 6);
        chk("abort_remiss_rdata", 0, rd, ref_mem[1088 >> 2]);
        chk("abort_remiss_rden", 0, srd, 1'b1);
        mdl_step(1'b0, 32'd1088, 32'd0, 3, ecyc, erd, erden, ewren);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] addr;
            logic [31:0] wd;
            int op;
            bit w;
            bit r;
            addr = 32'd1024 + 32'($urandom_range(0, 3)) * 512 + 32'($urandom_range(0, 3)) * 8
                   + 32'($urandom_range(0, 1)) * 4;
            wd = $urandom;
            op = $urandom_range(0, 9);
            w = (op >= 6);
            r = (op < 6) || (op == 9);
            sram_lat = $urandom_range(1, 4);
            mdl_step(w, addr, wd, sram_lat, ecyc, erd, erden, ewren);
            access(w, r, addr, wd, cyc, rd, srd, swr, bb);
            chk("rnd_cycles", i, cyc, ecyc);
            if (!w) chk("rnd_rdata", i, rd, erd);
            chk("rnd_rden", i, srd, erden);
            chk("rnd_wren", i, swr, ewren);
            chk("rnd_bus", i, bb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
